// File: rtl/hazard_if.sv
// hazard_if: bundle of signals between the pipeline datapath and the hazard sequencer.
//   master modport - datapath side: drives stage register/source info, receives stall,
//                    flush, forwarding selects, error flag and performance counters.
//   slave modport  - hazard_ctrl side: the mirror image.
// Signal names keep the pipeline-stage suffixes (D/E/M/W) used throughout the core.
interface hazard_if #(
    parameter int REGISTER_ADDRESS_WIDTH = 5,
    parameter int CNT_WIDTH              = 32
);
    // Decode / Execute / Memory / Writeback register indices and controls
    logic [REGISTER_ADDRESS_WIDTH-1:0] Rs1D_i, Rs2D_i;
    logic [REGISTER_ADDRESS_WIDTH-1:0] Rs1E_i, Rs2E_i, RdE_i;
    logic [1:0]                        ResultSrcE_i;
    logic                              PCSrcE_i;
    logic [REGISTER_ADDRESS_WIDTH-1:0] RdM_i;
    logic                              RegWriteM_i;
    logic [REGISTER_ADDRESS_WIDTH-1:0] RdW_i;
    logic                              RegWriteW_i;
    logic                              MemAccessM_i, MemReadyM_i;

    // Pipeline register controls, forwarding selects, status
    logic                              StallF_o, StallD_o, StallE_o, StallM_o, StallW_o;
    logic                              FlushD_o, FlushE_o;
    logic [1:0]                        ForwardAE_o, ForwardBE_o;
    logic                              MemErr_o;
    logic [CNT_WIDTH-1:0]              StallCnt_o, FlushCnt_o;

    modport master (
        output Rs1D_i, Rs2D_i, Rs1E_i, Rs2E_i, RdE_i, ResultSrcE_i, PCSrcE_i,
               RdM_i, RegWriteM_i, RdW_i, RegWriteW_i, MemAccessM_i, MemReadyM_i,
        input  StallF_o, StallD_o, StallE_o, StallM_o, StallW_o, FlushD_o, FlushE_o,
               ForwardAE_o, ForwardBE_o, MemErr_o, StallCnt_o, FlushCnt_o
    );

    modport slave (
        input  Rs1D_i, Rs2D_i, Rs1E_i, Rs2E_i, RdE_i, ResultSrcE_i, PCSrcE_i,
               RdM_i, RegWriteM_i, RdW_i, RegWriteW_i, MemAccessM_i, MemReadyM_i,
        output StallF_o, StallD_o, StallE_o, StallM_o, StallW_o, FlushD_o, FlushE_o,
               ForwardAE_o, ForwardBE_o, MemErr_o, StallCnt_o, FlushCnt_o
    );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencer for the 5-stage RV32 core.
//   clk_i  - clock, rising edge
//   rst_i  - asynchronous reset, active-high
//   hz     - hazard_if.slave: stage register indices/controls in; stall, flush,
//            forwarding selects, sticky memory-timeout error and saturating
//            stall/flush cycle counters out.
// Stall/flush/forwarding are combinational (zero latency); only the memory-wait
// FSM, its wait counter and the performance counters are registered.
module hazard_ctrl #(
    parameter int REGISTER_ADDRESS_WIDTH = 5,
    parameter int CNT_WIDTH              = 32,
    parameter int MEM_TIMEOUT            = 16
) (
    input logic     clk_i,
    input logic     rst_i,
    hazard_if.slave hz
);
    // Wide enough to hold MEM_TIMEOUT; saturates so a disabled timeout cannot wrap.
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 2);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [WAIT_W-1:0]    wait_cnt_q, wait_cnt_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

    logic       mem_busy, mem_stall, lw_stall;
    logic       stall_f, stall_d, stall_e, stall_m, stall_w;
    logic       flush_d, flush_e;
    logic [1:0] fwd_a, fwd_b;

    // Memory stage result beats Writeback result; x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [REGISTER_ADDRESS_WIDTH-1:0] rs,
        input logic [REGISTER_ADDRESS_WIDTH-1:0] rd_m,
        input logic                              we_m,
        input logic [REGISTER_ADDRESS_WIDTH-1:0] rd_w,
        input logic                              we_w
    );
        if (we_m && rd_m != '0 && rd_m == rs) return 2'b10;
        if (we_w && rd_w != '0 && rd_w == rs) return 2'b01;
        return 2'b00;
    endfunction

    assign mem_busy  = hz.MemAccessM_i & ~hz.MemReadyM_i;
    assign mem_stall = mem_busy | (state_q == ST_ERROR);
    assign lw_stall  = (hz.ResultSrcE_i == 2'b01) && (hz.RdE_i != '0) &&
                       ((hz.Rs1D_i == hz.RdE_i) || (hz.Rs2D_i == hz.RdE_i));

    // Pipeline control: memory stall > taken branch > load-use bubble.
    always_comb begin
        // NOTE: every output gets a default before any branch, so no latch is inferred.
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        stall_w = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        fwd_a   = 2'b00;
        fwd_b   = 2'b00;
        if (!rst_i) begin
            fwd_a = fwd_sel(hz.Rs1E_i, hz.RdM_i, hz.RegWriteM_i, hz.RdW_i, hz.RegWriteW_i);
            fwd_b = fwd_sel(hz.Rs2E_i, hz.RdM_i, hz.RegWriteM_i, hz.RdW_i, hz.RegWriteW_i);
            if (mem_stall) begin
                // Freeze everything; a branch in E is re-evaluated once released.
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
                stall_m = 1'b1;
                stall_w = 1'b1;
            end else if (hz.PCSrcE_i) begin
                // The load-use consumer in D is on the wrong path, so flushing wins.
                flush_d = 1'b1;
                flush_e = 1'b1;
            end else if (lw_stall) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
            end
        end
    end

    // Memory-wait FSM. wait_cnt counts stalled memory cycles seen so far, so a wait of
    // MEM_TIMEOUT cycles releases normally and the (MEM_TIMEOUT+1)-th stalled edge errors.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            ST_RUN: begin
                wait_cnt_d = '0;
                if (mem_busy) begin
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = WAIT_W'(1);
                end
            end
            ST_MEM_WAIT: begin
                if (!mem_busy) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else if (MEM_TIMEOUT > 0 && wait_cnt_q == WAIT_W'(MEM_TIMEOUT)) begin
                    state_d = ST_ERROR;
                end else if (wait_cnt_q != '1) begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            ST_ERROR: state_d = ST_ERROR;
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    // Saturating performance counters.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_f && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
        if (flush_e && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_WIDTH'(1);
    end

    // NOTE: all state here is control/status and must start known, so every flop is reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz.StallF_o    = stall_f;
    assign hz.StallD_o    = stall_d;
    assign hz.StallE_o    = stall_e;
    assign hz.StallM_o    = stall_m;
    assign hz.StallW_o    = stall_w;
    assign hz.FlushD_o    = flush_d;
    assign hz.FlushE_o    = flush_e;
    assign hz.ForwardAE_o = fwd_a;
    assign hz.ForwardBE_o = fwd_b;
    assign hz.MemErr_o    = (state_q == ST_ERROR);
    assign hz.StallCnt_o  = stall_cnt_q;
    assign hz.FlushCnt_o  = flush_cnt_q;
endmodule
